// File: rtl/top.sv
// 6502-subset CPU with byte-wide ROM at 0xF000-0xFFFF and RAM at 0x0000-0x01FF.
// One ph1 clock domain; the mem instance holds arrays loaded through hierarchy.

module top_mem #(
    parameter int ROM_WORDS    = 4096,
    parameter int RAM_WORDS    = 512,
    parameter bit ROM_WRITABLE = 1'b0
) (
    input  logic        clk,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata
);
    logic [7:0]  ROM [0:ROM_WORDS-1];
    logic [7:0]  RAM [0:RAM_WORDS-1];
    logic [8:0]  ram_idx;
    logic [11:0] rom_idx;
    logic        in_ram;
    logic        in_rom;

    assign ram_idx = addr[8:0];
    assign rom_idx = addr[11:0];
    assign in_ram  = (addr < 16'h0200) && (int'(ram_idx) < RAM_WORDS);
    assign in_rom  = (addr >= 16'hF000) && (int'(rom_idx) < ROM_WORDS);

    always_comb begin
        rdata = '0;
        if (in_ram) begin
            rdata = RAM[ram_idx];
        end else if (in_rom) begin
            rdata = ROM[rom_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (we && in_ram) begin
            RAM[ram_idx] <= wdata;
        end
    end

    // ROM image normally arrives through hierarchy; CPU stores are dropped.
    always_ff @(posedge clk) begin
        if (ROM_WRITABLE && we && in_rom) begin
            ROM[rom_idx] <= wdata;
        end
    end
endmodule

module top #(
    parameter int ROM_WORDS = 4096,
    parameter int RAM_WORDS = 512
) (
    input logic ph1,
    input logic resetb
);
    typedef enum logic [3:0] {
        RESET,
        VEC_LO,
        VEC_HI,
        FETCH,
        DECODE,
        OPERAND,
        EXEC,
        MEM,
        STACK
    } state_t;

    localparam logic [7:0] OP_CLC    = 8'h18;
    localparam logic [7:0] OP_SEC    = 8'h38;
    localparam logic [7:0] OP_CLI    = 8'h58;
    localparam logic [7:0] OP_SEI    = 8'h78;
    localparam logic [7:0] OP_CLD    = 8'hD8;
    localparam logic [7:0] OP_SED    = 8'hF8;
    localparam logic [7:0] OP_CLV    = 8'hB8;
    localparam logic [7:0] OP_NOP    = 8'hEA;
    localparam logic [7:0] OP_LDA_IM = 8'hA9;
    localparam logic [7:0] OP_LDX_IM = 8'hA2;
    localparam logic [7:0] OP_LDY_IM = 8'hA0;
    localparam logic [7:0] OP_LDA_ZP = 8'hA5;
    localparam logic [7:0] OP_STA_ZP = 8'h85;
    localparam logic [7:0] OP_STX_ZP = 8'h86;
    localparam logic [7:0] OP_STY_ZP = 8'h84;
    localparam logic [7:0] OP_ADC_IM = 8'h69;
    localparam logic [7:0] OP_TAX    = 8'hAA;
    localparam logic [7:0] OP_TXA    = 8'h8A;
    localparam logic [7:0] OP_TAY    = 8'hA8;
    localparam logic [7:0] OP_TYA    = 8'h98;
    localparam logic [7:0] OP_JMP    = 8'h4C;
    localparam logic [7:0] OP_PHA    = 8'h48;
    localparam logic [7:0] OP_PHP    = 8'h08;
    localparam logic [7:0] OP_PLA    = 8'h68;
    localparam logic [7:0] OP_PLP    = 8'h28;

    state_t      state;
    logic [7:0]  a;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [7:0]  sp;
    logic [7:0]  p;
    logic [15:0] pc;
    logic [7:0]  ir;
    logic [7:0]  opl;

    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic [8:0]  sum;
    logic        ovf;

    top_mem #(
        .ROM_WORDS(ROM_WORDS),
        .RAM_WORDS(RAM_WORDS)
    ) mem (
        .clk  (ph1),
        .addr (addr),
        .we   (we),
        .wdata(wdata),
        .rdata(rdata)
    );

    assign sum = {1'b0, a} + {1'b0, rdata} + {8'b0, p[0]};
    assign ovf = (a[7] == rdata[7]) && (sum[7] != a[7]);

    always_comb begin
        addr  = pc;
        we    = 1'b0;
        wdata = a;
        case (state)
            VEC_LO: addr = 16'hFFFC;
            VEC_HI: addr = 16'hFFFD;
            EXEC:   addr = {8'h01, sp};
            MEM: begin
                addr = {8'h00, opl};
                case (ir)
                    OP_STA_ZP: begin we = 1'b1; wdata = a; end
                    OP_STX_ZP: begin we = 1'b1; wdata = x; end
                    OP_STY_ZP: begin we = 1'b1; wdata = y; end
                    default: ;
                endcase
            end
            STACK: begin
                addr = {8'h01, sp};
                if (ir == OP_PHA) begin
                    we = 1'b1;
                end else if (ir == OP_PHP) begin
                    we    = 1'b1;
                    wdata = p | 8'h30;
                end
            end
            default: ;
        endcase
        // A store in flight when reset arrives must not land.
        if (resetb) begin
            we = 1'b0;
        end
    end

    always_ff @(posedge ph1) begin
        if (resetb) begin
            state <= RESET;
            a     <= '0;
            x     <= '0;
            y     <= '0;
            sp    <= 8'hFD;
            p     <= 8'h24;
            pc    <= '0;
            ir    <= '0;
            opl   <= '0;
        end else begin
            case (state)
                RESET: state <= VEC_LO;
                VEC_LO: begin
                    pc[7:0] <= rdata;
                    state   <= VEC_HI;
                end
                VEC_HI: begin
                    pc[15:8] <= rdata;
                    state    <= FETCH;
                end
                FETCH: begin
                    ir    <= rdata;
                    pc    <= pc + 16'd1;
                    state <= DECODE;
                end
                DECODE: begin
                    state <= FETCH;
                    case (ir)
                        OP_CLC: p[0] <= 1'b0;
                        OP_SEC: p[0] <= 1'b1;
                        OP_CLI: p[2] <= 1'b0;
                        OP_SEI: p[2] <= 1'b1;
                        OP_CLD: p[3] <= 1'b0;
                        OP_SED: p[3] <= 1'b1;
                        OP_CLV: p[6] <= 1'b0;
                        OP_NOP: ;
                        OP_LDA_IM: begin
                            a    <= rdata;
                            p[7] <= rdata[7];
                            p[1] <= (rdata == 8'h00);
                            pc   <= pc + 16'd1;
                        end
                        OP_LDX_IM: begin
                            x    <= rdata;
                            p[7] <= rdata[7];
                            p[1] <= (rdata == 8'h00);
                            pc   <= pc + 16'd1;
                        end
                        OP_LDY_IM: begin
                            y    <= rdata;
                            p[7] <= rdata[7];
                            p[1] <= (rdata == 8'h00);
                            pc   <= pc + 16'd1;
                        end
                        OP_LDA_ZP, OP_STA_ZP, OP_STX_ZP, OP_STY_ZP: begin
                            opl   <= rdata;
                            pc    <= pc + 16'd1;
                            state <= MEM;
                        end
                        OP_ADC_IM: begin
                            a    <= sum[7:0];
                            p[7] <= sum[7];
                            p[6] <= ovf;
                            p[1] <= (sum[7:0] == 8'h00);
                            p[0] <= sum[8];
                            pc   <= pc + 16'd1;
                        end
                        OP_TAX: begin
                            x    <= a;
                            p[7] <= a[7];
                            p[1] <= (a == 8'h00);
                        end
                        OP_TXA: begin
                            a    <= x;
                            p[7] <= x[7];
                            p[1] <= (x == 8'h00);
                        end
                        OP_TAY: begin
                            y    <= a;
                            p[7] <= a[7];
                            p[1] <= (a == 8'h00);
                        end
                        OP_TYA: begin
                            a    <= y;
                            p[7] <= y[7];
                            p[1] <= (y == 8'h00);
                        end
                        OP_JMP: begin
                            opl   <= rdata;
                            pc    <= pc + 16'd1;
                            state <= OPERAND;
                        end
                        OP_PHA, OP_PHP: state <= STACK;
                        OP_PLA, OP_PLP: state <= EXEC;
                        default: ;
                    endcase
                end
                OPERAND: begin
                    pc    <= {rdata, opl};
                    state <= FETCH;
                end
                EXEC: begin
                    sp    <= sp + 8'd1;
                    state <= STACK;
                end
                MEM: begin
                    if (ir == OP_LDA_ZP) begin
                        a    <= rdata;
                        p[7] <= rdata[7];
                        p[1] <= (rdata == 8'h00);
                    end
                    state <= FETCH;
                end
                STACK: begin
                    case (ir)
                        OP_PHA, OP_PHP: sp <= sp - 8'd1;
                        OP_PLA: begin
                            a    <= rdata;
                            p[7] <= rdata[7];
                            p[1] <= (rdata == 8'h00);
                        end
                        OP_PLP: p <= (rdata | 8'h20) & 8'hEF;
                        default: ;
                    endcase
                    state <= FETCH;
                end
                default: state <= RESET;
            endcase
        end
    end
endmodule

// File: tb/tb_top.sv
// Bench for the 6502-subset top: directed programs plus random programs checked
// instruction-by-instruction against an ISA-level reference interpreter.

module tb_top;
    logic ph1 = 1'b0;
    logic resetb = 1'b1;

    top #(.ROM_WORDS(4096), .RAM_WORDS(512)) dut (.ph1(ph1), .resetb(resetb));

    always #5 ph1 = ~ph1;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_rom [0:4095];
    logic [7:0]  m_ram [0:511];
    logic [7:0]  ma, mx, my, msp, mp;
    logic [15:0] mpc;
    logic [15:0] wp;

    logic [7:0] op_tab [0:27] = '{
        8'h18, 8'h38, 8'h58, 8'h78, 8'hD8, 8'hF8, 8'hB8, 8'hEA,
        8'hA9, 8'hA2, 8'hA0, 8'hA5, 8'h85, 8'h86, 8'h84, 8'h69,
        8'hAA, 8'h8A, 8'hA8, 8'h98, 8'h4C, 8'h48, 8'h08, 8'h68,
        8'h28, 8'h02, 8'hFF, 8'h13
    };

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge ph1);
        #1;
    endtask

    function automatic logic [7:0] mrd(input logic [15:0] ad);
        if (ad < 16'h0200) return m_ram[ad[8:0]];
        if (ad >= 16'hF000) return m_rom[ad[11:0]];
        return 8'h00;
    endfunction

    task automatic mwr(input logic [15:0] ad, input logic [7:0] v);
        if (ad < 16'h0200) m_ram[ad[8:0]] = v;
    endtask

    function automatic logic [7:0] nzf(input logic [7:0] pin, input logic [7:0] v);
        logic [7:0] r;
        r = pin;
        r[7] = v[7];
        r[1] = (v == 8'h00) ? 1'b1 : 1'b0;
        return r;
    endfunction

    function automatic int sval(input logic [7:0] v);
        return (v >= 8'h80) ? int'(v) - 256 : int'(v);
    endfunction

    function automatic int oplen(input logic [7:0] op);
        case (op)
            8'hA9, 8'hA2, 8'hA0, 8'hA5, 8'h85, 8'h86, 8'h84, 8'h69: return 1;
            8'h4C: return 2;
            default: return 0;
        endcase
    endfunction

    // Reference: one whole instruction per call, returning its cycle count.
    task automatic m_step(output int cyc);
        logic [7:0] op, b, lo;
        int s, ss;
        op = mrd(mpc);
        mpc = mpc + 16'd1;
        cyc = 2;
        case (op)
            8'h18: mp[0] = 1'b0;
            8'h38: mp[0] = 1'b1;
            8'h58: mp[2] = 1'b0;
            8'h78: mp[2] = 1'b1;
            8'hD8: mp[3] = 1'b0;
            8'hF8: mp[3] = 1'b1;
            8'hB8: mp[6] = 1'b0;
            8'hA9: begin ma = mrd(mpc); mpc = mpc + 16'd1; mp = nzf(mp, ma); end
            8'hA2: begin mx = mrd(mpc); mpc = mpc + 16'd1; mp = nzf(mp, mx); end
            8'hA0: begin my = mrd(mpc); mpc = mpc + 16'd1; mp = nzf(mp, my); end
            8'hA5: begin
                b = mrd(mpc); mpc = mpc + 16'd1;
                ma = mrd({8'h00, b}); mp = nzf(mp, ma); cyc = 3;
            end
            8'h85: begin b = mrd(mpc); mpc = mpc + 16'd1; mwr({8'h00, b}, ma); cyc = 3; end
            8'h86: begin b = mrd(mpc); mpc = mpc + 16'd1; mwr({8'h00, b}, mx); cyc = 3; end
            8'h84: begin b = mrd(mpc); mpc = mpc + 16'd1; mwr({8'h00, b}, my); cyc = 3; end
            8'h69: begin
                b = mrd(mpc); mpc = mpc + 16'd1;
                s  = int'(ma) + int'(b) + int'(mp[0]);
                ss = sval(ma) + sval(b) + int'(mp[0]);
                mp[0] = (s > 255) ? 1'b1 : 1'b0;
                mp[6] = (ss > 127 || ss < -128) ? 1'b1 : 1'b0;
                ma = 8'(s);
                mp = nzf(mp, ma);
            end
            8'hAA: begin mx = ma; mp = nzf(mp, mx); end
            8'h8A: begin ma = mx; mp = nzf(mp, ma); end
            8'hA8: begin my = ma; mp = nzf(mp, my); end
            8'h98: begin ma = my; mp = nzf(mp, ma); end
            8'h4C: begin
                lo = mrd(mpc); mpc = mpc + 16'd1;
                b = mrd(mpc);
                mpc = {b, lo}; cyc = 3;
            end
            8'h48: begin mwr({8'h01, msp}, ma); msp = msp - 8'd1; cyc = 3; end
            8'h08: begin mwr({8'h01, msp}, mp | 8'h30); msp = msp - 8'd1; cyc = 3; end
            8'h68: begin msp = msp + 8'd1; ma = mrd({8'h01, msp}); mp = nzf(mp, ma); cyc = 4; end
            8'h28: begin msp = msp + 8'd1; mp = (mrd({8'h01, msp}) | 8'h20) & 8'hEF; cyc = 4; end
            default: ;
        endcase
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 4096; i++) begin
            m_rom[i] = 8'h00;
            dut.mem.ROM[i] = 8'h00;
        end
        for (int i = 0; i < 512; i++) begin
            m_ram[i] = 8'h00;
            dut.mem.RAM[i] = 8'h00;
        end
        m_rom[12'hFFC] = 8'h00; dut.mem.ROM[12'hFFC] = 8'h00;
        m_rom[12'hFFD] = 8'hF0; dut.mem.ROM[12'hFFD] = 8'hF0;
        wp = 16'hF000;
    endtask

    task automatic put(input logic [7:0] b);
        m_rom[wp[11:0]] = b;
        dut.mem.ROM[wp[11:0]] = b;
        wp = wp + 16'd1;
    endtask

    task automatic put_ram(input logic [8:0] ad, input logic [7:0] b);
        m_ram[ad] = b;
        dut.mem.RAM[ad] = b;
    endtask

    task automatic jmp_self;
        logic [15:0] t;
        t = wp;
        put(8'h4C); put(t[7:0]); put(t[15:8]);
    endtask

    task automatic m_reset;
        ma = 8'h00; mx = 8'h00; my = 8'h00; msp = 8'hFD; mp = 8'h24;
        mpc = {mrd(16'hFFFD), mrd(16'hFFFC)};
    endtask

    task automatic reset_cpu(input int n);
        resetb = 1'b1;
        tick(n);
        chk("reset_regs", {dut.a, dut.x, dut.y, dut.sp, dut.p, dut.pc},
            {8'h00, 8'h00, 8'h00, 8'hFD, 8'h24, 16'h0000});
        resetb = 1'b0;
    endtask

    initial begin
        int n, cyc;
        logic [7:0] op, b;
        logic [15:0] tgt;

        // Minimal program: store lands within 20 cycles of release.
        clear_mem;
        put(8'hA9); put(8'hCE); put(8'h85); put(8'h30); jmp_self;
        reset_cpu(2);
        tick(3);
        chk("vector_pc", dut.pc, 16'hF000);
        tick(17);
        chk("lda_sta", dut.mem.RAM[9'h030], 8'hCE);

        // SEC; SED; PHP; PLA; STA
        clear_mem;
        put(8'h38); put(8'hF8); put(8'h08); put(8'h68); put(8'h85); put(8'h30); jmp_self;
        reset_cpu(2);
        tick(30);
        chk("php_flags", dut.mem.RAM[9'h030], 8'h3D);
        chk("php_sp", dut.sp, 8'hFD);

        // ADC overflow then CLV
        clear_mem;
        put(8'h58); put(8'h18); put(8'hA9); put(8'h7F); put(8'h69); put(8'h01);
        put(8'h08); put(8'h68); put(8'h85); put(8'h30);
        put(8'hB8); put(8'h08); put(8'h68); put(8'h85); put(8'h31); jmp_self;
        reset_cpu(2);
        tick(50);
        chk("adc_flags", dut.mem.RAM[9'h030], 8'hF0);
        chk("clv_flags", dut.mem.RAM[9'h031], 8'hB0);

        // PLP forcing of bits 5 and 4
        clear_mem;
        put(8'hA9); put(8'hC3); put(8'h48); put(8'h28); put(8'h08); put(8'h68);
        put(8'h85); put(8'h30); jmp_self;
        reset_cpu(2);
        tick(40);
        chk("plp_force", dut.mem.RAM[9'h030], 8'hF3);
        chk("plp_sp", dut.sp, 8'hFD);

        // Reset landing in the write cycle of STA
        clear_mem;
        put_ram(9'h030, 8'h11);
        put(8'hA9); put(8'hAA); put(8'h85); put(8'h30); jmp_self;
        reset_cpu(2);
        tick(7);
        resetb = 1'b1;
        tick(5);
        chk("abort_ram", dut.mem.RAM[9'h030], 8'h11);
        chk("abort_regs", {dut.a, dut.sp, dut.p, dut.pc}, {8'h00, 8'hFD, 8'h24, 16'h0000});
        resetb = 1'b0;
        tick(3);
        chk("restart_pc", dut.pc, 16'hF000);
        tick(10);
        chk("restart_sta", dut.mem.RAM[9'h030], 8'hAA);

        // Unimplemented opcode is a 1-byte NOP
        clear_mem;
        put(8'h02); put(8'hA9); put(8'h55); put(8'h85); put(8'h30); jmp_self;
        reset_cpu(2);
        tick(3 + 2);
        chk("unimpl_pc", dut.pc, 16'hF001);
        chk("unimpl_regs", {dut.a, dut.x, dut.y, dut.sp, dut.p},
            {8'h00, 8'h00, 8'h00, 8'hFD, 8'h24});
        tick(20);
        chk("unimpl_sta", dut.mem.RAM[9'h030], 8'h55);

        // PC wrap: NOP at 0xFFFF falls through into RAM at 0x0000
        clear_mem;
        put(8'h4C); put(8'hFF); put(8'hFF);
        m_rom[12'hFFF] = 8'hEA; dut.mem.ROM[12'hFFF] = 8'hEA;
        put_ram(9'h000, 8'hA9); put_ram(9'h001, 8'h77);
        put_ram(9'h002, 8'h85); put_ram(9'h003, 8'h30);
        put_ram(9'h004, 8'h4C); put_ram(9'h005, 8'h04); put_ram(9'h006, 8'h00);
        reset_cpu(2);
        tick(3 + 3 + 2);
        chk("pc_wrap", dut.pc, 16'h0000);
        tick(20);
        chk("wrap_sta", dut.mem.RAM[9'h030], 8'h77);

        // Random programs, compared against the interpreter at every boundary
        for (int r = 0; r < 4; r++) begin
            clear_mem;
            for (int i = 0; i < 16; i++) put_ram(9'(9'h030 + i), 8'($urandom));
            n = $urandom_range(20, 40);
            for (int i = 0; i < n; i++) begin
                op = op_tab[$urandom_range(0, 27)];
                put(op);
                if (op == 8'h4C) begin
                    tgt = wp + 16'd2;
                    put(tgt[7:0]); put(tgt[15:8]);
                end else if (oplen(op) == 1) begin
                    if (op == 8'hA5 || op == 8'h85 || op == 8'h86 || op == 8'h84)
                        b = 8'(8'h30 + $urandom_range(0, 15));
                    else
                        b = 8'($urandom);
                    put(b);
                end
            end
            jmp_self;
            m_reset;
            reset_cpu(2);
            tick(3);
            chk("rand_start", dut.pc, mpc);
            for (int i = 0; i < n; i++) begin
                m_step(cyc);
                tick(cyc);
                chk($sformatf("rand%0d_step%0d", r, i),
                    {dut.a, dut.x, dut.y, dut.sp, dut.p, dut.pc},
                    {ma, mx, my, msp, mp, mpc});
            end
            tick(6);
            chk($sformatf("rand%0d_jmpself", r), dut.pc, mpc);
            for (int i = 0; i < 512; i++) begin
                chk($sformatf("rand%0d_ram%0h", r, i), dut.mem.RAM[i], m_ram[i]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 SHALL have parameter ROM_WORDS, default 4096: ROM depth in bytes, mapped at 0xF000-0xFFFF.
REQ-002 SHALL have parameter RAM_WORDS, default 512: RAM depth in bytes, mapped at 0x0000-0x01FF (zero page plus stack page).
REQ-003 SHALL have port ph1, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port resetb, input, 1 bit: reset, synchronous and active-high; resetb=1 at a rising ph1 edge resets the block.
REQ-005 SHALL have no other ports; state is observed hierarchically.
REQ-006 SHALL contain an instance named mem holding byte arrays ROM[0:ROM_WORDS-1] and RAM[0:RAM_WORDS-1], both writable by a bench through hierarchy.

Function
REQ-007 SHALL implement an 8-bit 6502-subset CPU with 16-bit address bus: registers A, X, Y, SP, PC, P (N V 1 B D I Z C).
REQ-008 Memory reads SHALL be combinational from mem; writes SHALL commit on the rising ph1 edge; ROM writes from the CPU SHALL be ignored.
REQ-009 Addresses outside both ranges SHALL read 0x00 and ignore writes; RAM index SHALL be address[8:0], ROM index address[11:0].
REQ-010 After reset release, the CPU SHALL load PCL from 0xFFFC and PCH from 0xFFFD, with P=0x24 and SP=0xFD, then begin fetching.
REQ-011 SHALL decode CLC, SEC, CLI, SEI, CLD, SED and CLV (2 cycles each), each clearing or setting only its named flag.
REQ-012 SHALL decode NOP (2 cycles).
REQ-013 SHALL decode LDA/LDX/LDY immediate (2 cycles) and LDA zero page (3 cycles); each load SHALL update N and Z.
REQ-014 SHALL decode STA/STX/STY zero page (3 cycles).
REQ-015 SHALL decode ADC immediate (2 cycles), binary mode only; it SHALL update N, V, Z and C, where V is the signed overflow of A+M+C.
REQ-016 SHALL decode TAX, TXA, TAY and TYA (2 cycles), each updating N and Z.
REQ-017 SHALL decode JMP absolute (3 cycles).
REQ-018 SHALL decode PHA and PHP (3 cycles); stack address SHALL be 0x0100+SP, with post-decrement on push and pre-increment on pull; SP SHALL wrap modulo 256.
REQ-019 PHP SHALL push P with bits 5 and 4 (B) forced to 1.
REQ-020 SHALL decode PLA (4 cycles, updates N and Z) and PLP (4 cycles); PLP SHALL load P with bit 5 forced to 1 and B forced to 0.
REQ-021 Unimplemented opcodes SHALL execute as 2-cycle NOPs (PC+1) and leave all registers unchanged.
REQ-022 SHALL use a controller FSM with states RESET, VEC_LO, VEC_HI, FETCH, DECODE, OPERAND, EXEC, MEM, STACK, ending each instruction in FETCH.
REQ-023 PC SHALL wrap from 0xFFFF to 0x0000.
REQ-024 Asserting reset mid-instruction SHALL abort it at the next edge with no pending write committed.

Reset
REQ-025 While reset is asserted: FSM in RESET, A=X=Y=0, SP=0xFD, P=0x24, PC=0x0000, no memory writes; mem contents SHALL be untouched by reset.
REQ-026 The vector fetch SHALL start on the first rising edge with resetb=0.

Verification
REQ-027 ROM[0xFFC]=0x00, ROM[0xFFD]=0xF0; program LDA #$CE; STA $30; JMP self -> RAM[0x30]=0xCE within 20 cycles.
REQ-028 SEC; SED; PHP; PLA; STA $30 -> RAM[0x30]=0x3D; SP returns to 0xFD.
REQ-029 CLI; CLC; LDA #$7F; ADC #$01; PHP; PLA; STA $30 -> RAM[0x30]=0xF0 (N=1, V=1, Z=0, C=0); CLV; PHP; PLA; STA $31 -> RAM[0x31]=0xB0.
REQ-030 LDA #$C3; PHA; PLP; PHP; PLA; STA $30 -> RAM[0x30]=0xF3.
REQ-031 Reset asserted for 5 cycles in the middle of STA $30 -> RAM[0x30] unchanged, and execution restarts at 0xF000.
REQ-032 Unimplemented opcode 0x02 followed by LDA #$55; STA $30 -> RAM[0x30]=0x55.
